serial_cmp_ctrl: RTL

SERIAL_CMP_CTRL -- requirements
Module: serial_cmp_ctrl

---
 rtl/cmp_pkg.sv | 15 +
 rtl/eq_bit_cell.sv | 16 +
 rtl/serial_cmp_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// Shared types and constants for the serial magnitude comparator.
// The counter is sized for the largest supported operand width so that one
// encoding serves every legal WIDTH setting.
package cmp_pkg;

    localparam int MAX_WIDTH = 32;
    localparam int CNT_W     = $clog2(MAX_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/eq_bit_cell.sv
// One-bit comparison cell: reports whether two bits are equal and whether
// x is strictly greater than y. "Less than" is implied when neither is set.
module eq_bit_cell (
    input  logic x,
    input  logic y,
    output logic eq,
    output logic gt
);

    // Pure combinational compare of a single bit pair.
    always_comb begin
        eq = ~(x ^ y);
        gt = x & ~y;
    end

endmodule

// File: rtl/serial_cmp_ctrl.sv
// Serial unsigned magnitude comparator. Operands are latched on an accepted
// start, then compared one bit pair per cycle from the MSB down using a single
// eq_bit_cell. The first differing pair decides the result.
// Optional build macro: SERIAL_CMP_EARLY_EXIT_EN -- when defined, the shift
// phase ends right after the first differing bit pair instead of always
// running WIDTH cycles.
module serial_cmp_ctrl
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    state_t             state;
    logic [WIDTH-1:0]   sh_a;
    logic [WIDTH-1:0]   sh_b;
    logic [CNT_W-1:0]   cnt;
    logic               dec_gt;
    logic               dec_lt;

    logic               cell_eq;
    logic               cell_gt;
    logic               undecided;
    logic               nxt_gt;
    logic               nxt_lt;
    logic               shift_exit;

    eq_bit_cell u_cell (
        .x  (sh_a[WIDTH-1]),
        .y  (sh_b[WIDTH-1]),
        .eq (cell_eq),
        .gt (cell_gt)
    );

    // Fold the current bit pair into the decision and decide whether this is the last shift cycle.
    always_comb begin
        undecided = ~dec_gt & ~dec_lt;
        nxt_gt    = dec_gt | (undecided & ~cell_eq &  cell_gt);
        nxt_lt    = dec_lt | (undecided & ~cell_eq & ~cell_gt);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        shift_exit = (cnt == CNT_W'(1)) | (undecided & ~cell_eq);
`else
        shift_exit = (cnt == CNT_W'(1));
`endif
    end

    // Control FSM with registered busy/done/result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sh_a   <= '0;
            sh_b   <= '0;
            cnt    <= '0;
            dec_gt <= 1'b0;
            dec_lt <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            eq     <= 1'b0;
            gt     <= 1'b0;
            lt     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sh_a   <= a;
                        sh_b   <= b;
                        cnt    <= CNT_W'(WIDTH);
                        dec_gt <= 1'b0;
                        dec_lt <= 1'b0;
                        eq     <= 1'b0;
                        gt     <= 1'b0;
                        lt     <= 1'b0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end else begin
                        state  <= IDLE;
                    end
                end
                SHIFT: begin
                    sh_a   <= sh_a << 1;
                    sh_b   <= sh_b << 1;
                    cnt    <= cnt - CNT_W'(1);
                    dec_gt <= nxt_gt;
                    dec_lt <= nxt_lt;
                    if (shift_exit) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        gt    <= nxt_gt;
                        lt    <= nxt_lt;
                        eq    <= ~nxt_gt & ~nxt_lt;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
